// File: rtl/pwm_capture.sv
// pwm_capture
//   Measures an external, asynchronous PWM signal. Reports the high time and
//   the period (rising edge to rising edge) of the last complete period in clk
//   cycles. A one-cycle strobe marks every update. A timeout flag is raised when
//   rising edges stop, and the pin level seen at that moment is latched so that
//   0% and 100% duty can be told apart.
// Ports
//   clk        in   1      system clock
//   rst        in   1      synchronous reset, active-high
//   en         in   1      capture enable; low forces IDLE
//   pwm_in     in   1      asynchronous PWM input
//   high_time  out  NBITS  high cycles of the last complete period
//   period     out  NBITS  cycles between the last two rising edges
//   valid      out  1      one-cycle pulse when high_time/period update
//   timeout    out  1      no rising edge for TIMEOUT cycles (held until next valid)
//   level      out  1      synchronised pin value latched at timeout
//   dbg_state  out  2      current FSM state (0 IDLE, 1 HIGH, 2 LOW)
module pwm_capture #(
  parameter int NBITS       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 2**NBITS-1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pwm_in,
  output logic [NBITS-1:0] high_time,
  output logic [NBITS-1:0] period,
  output logic             valid,
  output logic             timeout,
  output logic             level,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  localparam logic [NBITS-1:0] LP_TIMEOUT = NBITS'(TIMEOUT);
  localparam logic [NBITS-1:0] LP_ONE     = NBITS'(1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [SYNC_STAGES-1:0]  r_sync;
  logic                    r_prev;
  logic                    w_s;
  logic                    w_rise;
  logic                    w_fall;
  logic                    w_expired;
  logic [NBITS-1:0]        r_pcnt;
  logic [NBITS-1:0]        r_hcnt;
  logic [NBITS-1:0]        r_ht;
  logic [NBITS-1:0]        r_per;
  logic                    r_valid;
  logic                    r_timeout;
  logic                    r_level;
  logic [NBITS-1:0]        w_pcnt_nxt;
  logic [NBITS-1:0]        w_hcnt_nxt;
  logic [NBITS-1:0]        w_ht_nxt;
  logic [NBITS-1:0]        w_per_nxt;
  logic                    w_valid_nxt;
  logic                    w_timeout_nxt;
  logic                    w_level_nxt;

  // Synchroniser and edge detector keep sampling regardless of en.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pwm_in};
      r_prev <= w_s;
    end
  end

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_rise = w_s & ~r_prev;
  assign w_fall = ~w_s & r_prev;
  // A rising edge always wins over an expiring count.
  assign w_expired = !w_rise && (r_pcnt == LP_TIMEOUT);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic. A rise seen in HIGH (should not happen) follows the
  // LOW rule, i.e. it closes the period and starts a new HIGH.
  always_comb begin
    w_state_nxt = r_state;
    if (!en) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_rise) w_state_nxt = ST_HIGH;
        ST_HIGH: begin
          if (w_rise)         w_state_nxt = ST_HIGH;
          else if (w_expired) w_state_nxt = ST_IDLE;
          else if (w_fall)    w_state_nxt = ST_LOW;
        end
        ST_LOW: begin
          if (w_rise)         w_state_nxt = ST_HIGH;
          else if (w_expired) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output / datapath logic. The rise cycle counts as the first high cycle;
  // the fall cycle counts toward the period only.
  always_comb begin
    w_pcnt_nxt    = r_pcnt;
    w_hcnt_nxt    = r_hcnt;
    w_ht_nxt      = r_ht;
    w_per_nxt     = r_per;
    w_valid_nxt   = 1'b0;
    w_timeout_nxt = r_timeout;
    w_level_nxt   = r_level;
    if (!en) begin
      w_pcnt_nxt    = '0;
      w_hcnt_nxt    = '0;
      w_timeout_nxt = 1'b0;
    end else if (r_state == ST_IDLE) begin
      if (w_rise) begin
        w_pcnt_nxt = LP_ONE;
        w_hcnt_nxt = LP_ONE;
      end
    end else if (w_rise) begin
      w_ht_nxt      = r_hcnt;
      w_per_nxt     = r_pcnt;
      w_valid_nxt   = 1'b1;
      w_timeout_nxt = 1'b0;
      w_pcnt_nxt    = LP_ONE;
      w_hcnt_nxt    = LP_ONE;
    end else if (w_expired) begin
      w_timeout_nxt = 1'b1;
      w_level_nxt   = w_s;
      w_pcnt_nxt    = '0;
      w_hcnt_nxt    = '0;
    end else begin
      w_pcnt_nxt = r_pcnt + LP_ONE;
      if (r_state == ST_HIGH && !w_fall) w_hcnt_nxt = r_hcnt + LP_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pcnt    <= '0;
      r_hcnt    <= '0;
      r_ht      <= '0;
      r_per     <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_level   <= 1'b0;
    end else begin
      r_pcnt    <= w_pcnt_nxt;
      r_hcnt    <= w_hcnt_nxt;
      r_ht      <= w_ht_nxt;
      r_per     <= w_per_nxt;
      r_valid   <= w_valid_nxt;
      r_timeout <= w_timeout_nxt;
      r_level   <= w_level_nxt;
    end
  end

  assign high_time = r_ht;
  assign period    = r_per;
  assign valid     = r_valid;
  assign timeout   = r_timeout;
  assign level     = r_level;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture
//   Drives pwm_capture with directed and randomised PWM waveforms and compares
//   every output, every cycle, against a reference computed from the sampled
//   input history (rise-to-rise distances and high-sample counts).
module tb_pwm_capture;

  localparam int NBITS = 16;
  localparam int SS    = 2;
  localparam int TO    = 100;
  localparam int MAXC  = 20000;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             pwm_in;
  logic [NBITS-1:0] high_time;
  logic [NBITS-1:0] period;
  logic             valid;
  logic             timeout;
  logic             level;
  logic [1:0]       dbg_state;

  always #5 clk = ~clk;

  pwm_capture #(.NBITS(NBITS), .SYNC_STAGES(SS), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .pwm_in    (pwm_in),
    .high_time (high_time),
    .period    (period),
    .valid     (valid),
    .timeout   (timeout),
    .level     (level),
    .dbg_state (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int ecount   = 0;

  logic in_h  [MAXC];
  logic rst_h [MAXC];
  logic en_h  [MAXC];
  logic s_h   [MAXC];

  // reference state
  int   last_rst   = 0;
  int   last_rise  = 0;
  bit   armed      = 0;
  int   e_ht       = 0;
  int   e_per      = 0;
  bit   e_valid    = 0;
  bit   e_to       = 0;
  bit   e_lvl      = 0;
  int   exp_valids = 0;
  int   dut_valids = 0;
  int   exp_tos    = 0;
  int   dut_tos    = 0;
  bit   prev_dut_to = 0;

  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", tag, ecount, obs, exp);
    end
  endtask

  // Reference: expected outputs after clock edge m, derived from the sampled
  // input history. The pin value seen by the measurement logic at edge m is the
  // pin as sampled SS edges earlier (zero if that sample predates a reset).
  task automatic model(input int m);
    bit s, p;
    int hi;
    e_valid = 0;
    if (rst_h[m]) begin
      last_rst = m;
      s_h[m]   = 1'b0;
      armed    = 0;
      e_ht = 0; e_per = 0; e_to = 0; e_lvl = 0;
      exp_q.delete();
      return;
    end
    s = (m - SS > last_rst) ? in_h[m-SS] : 1'b0;
    s_h[m] = s;
    p = s_h[m-1];
    if (!en_h[m]) begin
      armed = 0;
      e_to  = 0;
    end else if (s && !p) begin
      if (armed) begin
        hi = 0;
        for (int k = last_rise; k < m; k++) hi += int'(s_h[k]);
        e_ht    = hi;
        e_per   = m - last_rise;
        e_valid = 1;
        e_to    = 0;
        exp_valids++;
        exp_q.push_back({e_per[15:0], e_ht[15:0]});
      end
      armed     = 1;
      last_rise = m;
    end else if (armed && (m - last_rise == TO)) begin
      e_to  = 1;
      e_lvl = s;
      armed = 0;
      exp_tos++;
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit r, input bit e, input bit p);
    logic [31:0] got;
    @(negedge clk);
    rst = r; en = e; pwm_in = p;
    rst_h[ecount] = r; en_h[ecount] = e; in_h[ecount] = p;
    @(posedge clk);
    model(ecount);
    #1;
    check("high_time", 32'(high_time), 32'(e_ht));
    check("period",    32'(period),    32'(e_per));
    check("valid",     32'(valid),     32'(e_valid));
    check("timeout",   32'(timeout),   32'(e_to));
    check("level",     32'(level),     32'(e_lvl));
    check("idle",      32'(dbg_state == 2'd0), 32'(!armed));
    if (valid) begin
      dut_valids++;
      if (exp_q.size() == 0) begin
        check("strobe_unexpected", 32'(1), 32'(0));
      end else begin
        got = exp_q.pop_front();
        check("strobe_pair", {period, high_time}, got);
      end
    end
    if (timeout && !prev_dut_to) dut_tos++;
    prev_dut_to = timeout;
    ecount++;
    if (ecount >= MAXC) begin
      $display("FAIL cycle_budget: got %0d expected below %0d", ecount, MAXC);
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "cycle budget exhausted");
    end
  endtask

  task automatic pulses(input int h, input int l, input int n, input bit e);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < h; j++) step(1'b0, e, 1'b1);
      for (int j = 0; j < l; j++) step(1'b0, e, 1'b0);
    end
  endtask

  task automatic hold(input bit v, input int n, input bit e);
    for (int i = 0; i < n; i++) step(1'b0, e, v);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; en = 1'b0; pwm_in = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
    hold(1'b0, 4, 1'b1);

    // basic periodic waveform
    pulses(3, 5, 6, 1'b1);

    // duty change: old values until the first full new period
    pulses(10, 10, 3, 1'b1);
    pulses(2, 18, 3, 1'b1);

    // stuck high -> timeout with level 1, then recovery
    hold(1'b1, 130, 1'b1);
    pulses(4, 4, 4, 1'b1);

    // reset in the middle of a high phase
    pulses(6, 6, 2, 1'b1);
    hold(1'b1, 3, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    hold(1'b1, 3, 1'b1);
    pulses(5, 7, 4, 1'b1);

    // enable dropped for 20 cycles in a low phase
    pulses(5, 3, 2, 1'b1);
    hold(1'b0, 2, 1'b1);
    hold(1'b0, 20, 1'b0);
    hold(1'b0, 3, 1'b1);
    pulses(7, 9, 4, 1'b1);

    // minimum pulse width
    pulses(1, 1, 10, 1'b1);

    // stuck low -> timeout with level 0
    hold(1'b0, 150, 1'b1);

    // randomised waveforms with occasional enable drops and stalls
    for (int i = 0; i < 40; i++) begin
      pulses($urandom_range(1, 40), $urandom_range(1, 40), $urandom_range(1, 3), 1'b1);
      case ($urandom_range(0, 7))
        0: hold(1'b0, $urandom_range(1, 30), 1'b0);
        1: hold(1'($urandom_range(0, 1)), $urandom_range(90, 130), 1'b1);
        2: step(1'b1, 1'b1, 1'($urandom_range(0, 1)));
        default: ;
      endcase
    end
    hold(1'b0, 8, 1'b1);

    check("valid_count",   32'(dut_valids), 32'(exp_valids));
    check("timeout_count", 32'(dut_tos),    32'(exp_tos));
    check("strobe_queue_empty", 32'(exp_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
